kernel3x3_pipe: RTL



---
 rtl/kernel3x3_pipe_if.sv | 35 +++
 rtl/kernel3x3_pipe.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/kernel3x3_pipe_if.sv
// Window-in / pixel-out bus of kernel3x3_pipe, with coefficient programming and
// normalisation control. master = upstream/downstream driver, slave = kernel.
interface kernel3x3_pipe_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COEF_WIDTH  = 5,
  parameter int unsigned SHIFT_WIDTH = 4
) ();
  logic                    coef_wr_en;
  logic [3:0]              coef_wr_addr;
  logic [COEF_WIDTH-1:0]   coef_wr_data;
  logic                    coef_commit;
  logic [SHIFT_WIDTH-1:0]  norm_shift;
  logic                    win_valid;
  logic                    win_ready;
  logic                    win_sof;
  logic [9*DATA_WIDTH-1:0] win_data;
  logic [8:0]              border_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [1:0]              out_sat;
  logic                    commit_pending;

  modport master (
    output coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit, norm_shift,
    output win_valid, win_sof, win_data, border_mask, out_ready,
    input  win_ready, out_valid, out_data, out_sat, commit_pending
  );

  modport slave (
    input  coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit, norm_shift,
    input  win_valid, win_sof, win_data, border_mask, out_ready,
    output win_ready, out_valid, out_data, out_sat, commit_pending
  );
endinterface

// File: rtl/kernel3x3_pipe.sv
// 3-stage 3x3 convolution: products, row sums, then round/shift/clamp, under a global stall.
// Define KERNEL3X3_ABS_OUT_EN to output |r| (edge magnitude) instead of clamping negatives to 0.
module kernel3x3_pipe #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COEF_WIDTH  = 5,
  parameter int unsigned SHIFT_WIDTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  kernel3x3_pipe_if.slave  bus
);

  localparam int unsigned AccW = DATA_WIDTH + COEF_WIDTH + 4;

  typedef logic signed [AccW-1:0]       acc_t;
  typedef logic [8:0][COEF_WIDTH-1:0]   bank_t;

  localparam acc_t MaxPix = acc_t'({DATA_WIDTH{1'b1}});

  // Laplacian-style default: corners -1, edges 0, centre 4.
  function automatic bank_t reset_bank();
    bank_t b;
    for (int k = 0; k < 9; k++) begin
      if (k == 4)          b[k] = COEF_WIDTH'(4);
      else if (k % 2 == 0) b[k] = '1;
      else                 b[k] = '0;
    end
    return b;
  endfunction

  bank_t active_q, active_d, shadow_q, shadow_d, coef_use;
  logic  commit_pending_q, commit_pending_d;

  logic  stall, accept, idle, transfer;

  logic  s1_valid_q, s2_valid_q, out_valid_q;
  acc_t  pix_ext  [9];
  acc_t  coef_ext [9];
  acc_t  prod_d   [9];
  acc_t  prod_q   [9];
  acc_t  row_d    [3];
  acc_t  row_q    [3];

  acc_t  sum, rnd, rsum, r;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            out_sat_q, out_sat_d;

  assign stall    = out_valid_q && !bus.out_ready;
  assign accept   = bus.win_valid && !stall;
  assign idle     = !bus.win_valid && !s1_valid_q && !s2_valid_q && !out_valid_q;
  assign transfer = commit_pending_q && ((accept && bus.win_sof) || idle);

  // A sof beat accepted on the transfer edge must already see the new bank.
  assign coef_use = transfer ? shadow_q : active_q;

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (transfer) active_d = shadow_q;
    if (bus.coef_wr_en && (bus.coef_wr_addr < 4'd9)) begin
      shadow_d[bus.coef_wr_addr] = bus.coef_wr_data;
    end
    if (bus.coef_commit)  commit_pending_d = 1'b1;
    else if (transfer)    commit_pending_d = 1'b0;
    else                  commit_pending_d = commit_pending_q;
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      pix_ext[k]  = acc_t'(bus.win_data[k*DATA_WIDTH +: DATA_WIDTH]);
      coef_ext[k] = acc_t'(signed'(coef_use[k]));
      prod_d[k]   = bus.border_mask[k] ? '0 : pix_ext[k] * coef_ext[k];
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      row_d[i] = prod_q[3*i] + prod_q[3*i+1] + prod_q[3*i+2];
    end
  end

  always_comb begin
    sum  = row_q[0] + row_q[1] + row_q[2];
    rnd  = '0;
    if (bus.norm_shift != '0) rnd = acc_t'(1) << (bus.norm_shift - 1'b1);
    rsum = sum + rnd;
    r    = rsum >>> bus.norm_shift;
`ifdef KERNEL3X3_ABS_OUT_EN
    if (r < 0) r = -r;
`endif
    out_data_d = r[DATA_WIDTH-1:0];
    out_sat_d  = 2'b00;
    if (r < 0) begin
      out_data_d = '0;
      out_sat_d  = 2'b10;
    end else if (r > MaxPix) begin
      out_data_d = '1;
      out_sat_d  = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q         <= reset_bank();
      shadow_q         <= reset_bank();
      commit_pending_q <= 1'b0;
    end else begin
      active_q         <= active_d;
      shadow_q         <= shadow_d;
      commit_pending_q <= commit_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      for (int i = 0; i < 3; i++) row_q[i] <= '0;
    end else if (!stall) begin
      s1_valid_q  <= bus.win_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      if (bus.win_valid) begin
        for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      end
      if (s1_valid_q) begin
        for (int i = 0; i < 3; i++) row_q[i] <= row_d[i];
      end
      if (s2_valid_q) begin
        out_data_q <= out_data_d;
        out_sat_q  <= out_sat_d;
      end
    end
  end

  assign bus.win_ready      = !stall;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_data       = out_data_q;
  assign bus.out_sat        = out_sat_q;
  assign bus.commit_pending = commit_pending_q;

endmodule
